// File: rtl/dbg_pkg.sv
// Shared types for the core-side debug responder: command codes, register
// address width and the responder state encoding.
package dbg_pkg;

    localparam int DBG_REG_AW = 5;

    typedef enum logic [7:0] {
        CMD_NOP    = 8'h00,
        CMD_HALT   = 8'h01,
        CMD_RESUME = 8'h02,
        CMD_RD_REG = 8'h03,
        CMD_WR_REG = 8'h04,
        CMD_RD_PC  = 8'h05,
        CMD_WR_PC  = 8'h06
    } dbg_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HALT_WAIT,
        ST_DONE
    } dbg_state_e;

endpackage

// File: rtl/dbg_intf.sv
// Link between the system debug module (dbg side) and the core responder (dut side).
interface dbg_intf;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data_dbg_dut;
    logic [31:0] data_dut_dbg;
    logic        dut_done;

    modport dut (input cmd, input addr, input data_dbg_dut,
                 output data_dut_dbg, output dut_done);
    modport dbg (output cmd, output addr, output data_dbg_dut,
                 input data_dut_dbg, input dut_done);
endinterface

// File: rtl/core_dbg_module.sv
// Core-side debug responder: executes halt/resume, register and IF-PC access
// commands and acknowledges each one with a single-cycle dut_done pulse.
module core_dbg_module
    import dbg_pkg::*;
#(
    parameter int          HALT_TIMEOUT = 1024,
    parameter bit          RESET_HALTED = 1'b0,
    parameter logic [31:0] ERR_DATA     = 32'hBAD0_0000
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    dbg_intf.dut                  dbg_bus,
    input  logic                  core_idle_i,
    input  logic [31:0]           if_pc_i,
    input  logic [31:0]           rf_rdata_i,
    output logic                  halt_o,
    output logic                  halted_o,
    output logic [DBG_REG_AW-1:0] rf_addr_o,
    output logic [31:0]           rf_wdata_o,
    output logic                  rf_we_o,
    output logic [31:0]           pc_wdata_o,
    output logic                  pc_we_o,
    output logic                  flush_o
);

    localparam int CW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;

    dbg_state_e            r_state;
    logic [7:0]            r_cmd;
    logic [CW-1:0]         r_cnt;
    logic                  r_halt, r_halted;
    logic [DBG_REG_AW-1:0] r_rf_addr;
    logic [31:0]           r_rf_wdata, r_pc_wdata, r_rdata;
    logic                  r_rf_we, r_pc_we, r_flush, r_done;
    logic [DBG_REG_AW-1:0] w_addr;
    logic                  w_unused;

    assign w_addr   = dbg_bus.addr[DBG_REG_AW-1:0];
    assign w_unused = ^dbg_bus.addr[31:DBG_REG_AW];

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= ST_IDLE;
            r_cmd      <= CMD_NOP;
            r_cnt      <= '0;
            r_halt     <= RESET_HALTED;
            r_halted   <= RESET_HALTED;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_pc_wdata <= '0;
            r_rdata    <= '0;
            r_rf_we    <= 1'b0;
            r_pc_we    <= 1'b0;
            r_flush    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (dbg_bus.cmd != CMD_NOP) begin
                        r_cmd <= dbg_bus.cmd;
                        if (dbg_bus.cmd == CMD_HALT) begin
                            r_state <= ST_HALT_WAIT;
                            r_halt  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_EXEC;
                            // Strobes are launched here so they are high exactly during EXEC
                            case (dbg_bus.cmd)
                                CMD_RESUME: begin
                                    r_halt   <= 1'b0;
                                    r_halted <= 1'b0;
                                end
                                CMD_RD_REG: if (r_halted) r_rf_addr <= w_addr;
                                CMD_WR_REG: if (r_halted) begin
                                    r_rf_addr  <= w_addr;
                                    r_rf_wdata <= dbg_bus.data_dbg_dut;
                                    r_rf_we    <= (w_addr != '0);
                                end
                                CMD_WR_PC: if (r_halted) begin
                                    r_pc_wdata <= dbg_bus.data_dbg_dut;
                                    r_pc_we    <= 1'b1;
                                    r_flush    <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_rf_we <= 1'b0;
                    r_pc_we <= 1'b0;
                    r_flush <= 1'b0;
                    case (r_cmd)
                        CMD_RD_REG: r_rdata <= r_halted ? rf_rdata_i : ERR_DATA;
                        CMD_RD_PC:  r_rdata <= r_halted ? if_pc_i : ERR_DATA;
                        default: ;
                    endcase
                end
                ST_HALT_WAIT: begin
                    // A timeout leaves halt_o asserted so a retried halt can still succeed
                    if (r_halted) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (core_idle_i) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                    end else if (r_cnt == CW'(HALT_TIMEOUT - 1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign halt_o               = r_halt;
    assign halted_o             = r_halted;
    assign rf_addr_o            = r_rf_addr;
    assign rf_wdata_o           = r_rf_wdata;
    assign rf_we_o              = r_rf_we;
    assign pc_wdata_o           = r_pc_wdata;
    assign pc_we_o              = r_pc_we;
    assign flush_o              = r_flush;
    assign dbg_bus.data_dut_dbg = r_rdata;
    assign dbg_bus.dut_done     = r_done;

endmodule

// File: doc/core_dbg_module.md
Name: core_dbg_module

Overview:
- Core-side responder of the debug interface. Executes debug commands inside the core: halt, resume, register read/write and IF-stage PC read/write.
- Sits in the core top, between the dbg_intf link from the system debug module and the core pipeline, register file debug port and fetch stage.
- Completion of every command is signalled by a single-cycle dut_done pulse.

Parameters:
- HALT_TIMEOUT, 1024: max cycles to wait for core_idle_i after a halt request.
- RESET_HALTED, 0: 1 means the core comes out of reset halted.
- ERR_DATA, 32'hBAD0_0000: value returned for a register/PC read while the core is not halted.

Ports:
- clk  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- dbg_bus  dbg_intf.dut  -  interface; fields below are listed from this block's side.
- dbg_bus.cmd  in  8  command: 00 nop, 01 halt, 02 resume, 03 rd reg, 04 wr reg, 05 rd PC, 06 wr PC
- dbg_bus.addr  in  32  register index; bits [4:0] used
- dbg_bus.data_dbg_dut  in  32  write data
- dbg_bus.data_dut_dbg  out  32  read data
- dbg_bus.dut_done  out  1  command complete (1-cycle pulse)
- core_idle_i  in  1  pipeline drained, no outstanding bus access
- if_pc_i  in  32  current IF-stage PC
- rf_rdata_i  in  32  register file debug read data; combinational from rf_addr_o
- halt_o  out  1  stall fetch / freeze pipeline
- halted_o  out  1  core confirmed halted
- rf_addr_o  out  5  register file debug address
- rf_wdata_o  out  32  register file debug write data
- rf_we_o  out  1  register file debug write strobe
- pc_wdata_o  out  32  new IF PC
- pc_we_o  out  1  PC write strobe
- flush_o  out  1  pipeline flush

Behaviour:
- Reset values:
  - halt_o = halted_o = RESET_HALTED.
  - All strobes, dut_done, rf_addr_o, rf_wdata_o, pc_wdata_o and data_dut_dbg are 0.
  - State is IDLE and the wait counter is 0.
- All outputs are registered.
- States: IDLE, EXEC, HALT_WAIT, DONE.
- IDLE:
  - cmd == 0: stay.
  - Otherwise latch cmd, addr[4:0] and data_dbg_dut. Go to HALT_WAIT for 01, else EXEC.
- Latched values are used to completion. Later changes or drops on cmd are ignored until the next IDLE.
- EXEC lasts exactly 1 cycle, then DONE. dut_done is high for the one DONE cycle, then IDLE. Completion is therefore 2 cycles after cmd is first sampled. Per command:
  - 02 resume: halt_o <= 0 and halted_o <= 0 on entering EXEC.
  - 03 rd reg, halted: rf_addr_o driven in EXEC; rf_rdata_i captured into data_dut_dbg at the end of EXEC.
  - 04 wr reg, halted: rf_we_o high for the EXEC cycle with rf_addr_o/rf_wdata_o. Address 0 produces no strobe but still completes.
  - 05 rd PC, halted: if_pc_i captured at the end of EXEC.
  - 06 wr PC, halted: pc_we_o and flush_o high together for the EXEC cycle.
  - 03/05 while not halted: data_dut_dbg <= ERR_DATA, no strobes.
  - 04/06 while not halted: no strobes.
  - Unknown codes: no side effects, data_dut_dbg unchanged.
- HALT_WAIT:
  - halt_o <= 1 on entry; the counter clears on entry and increments each cycle.
  - core_idle_i sampled 1: halted_o <= 1, go to DONE.
  - Counter reaches HALT_TIMEOUT-1: go to DONE with halted_o still 0 and halt_o left at 1; a later halt retries.
  - Already halted on entry: core_idle_i is ignored and the block goes to DONE next cycle.
- DONE: cmd is ignored. The initiator drops cmd combinationally on dut_done. If the host still holds the command, it is re-issued and re-executed; all commands are idempotent.
- data_dut_dbg holds its value until the next read-type completion.
- Reset mid-command: immediate return to reset values. No strobe and no dut_done are produced.

Decomposition:
- Shared package dbg_pkg holds:
  - enum dbg_cmd_e with codes 00-06 (8 bit);
  - localparam DBG_REG_AW = 5;
  - the state enum typedef.
- No sub-module; the wait counter is inline.

Test Plan:
- Reset with RESET_HALTED=0, then cmd=01 with core_idle_i rising 5 cycles later -> halt_o high 1 cycle after cmd; halted_o and dut_done high together once, then back to IDLE.
- Halted; cmd=03, addr=7, rf_rdata_i=32'h1234_5678 -> rf_addr_o=7 in EXEC; dut_done 2 cycles after cmd with data_dut_dbg=32'h1234_5678.
- Halted; cmd=04, addr=0 then addr=3, data 32'hCAFE -> no rf_we_o for x0; single rf_we_o pulse with rf_addr_o=3 and rf_wdata_o=32'hCAFE; dut_done for both.
- Halted; cmd=06, data 32'h8000_0100 -> pc_we_o and flush_o one cycle with pc_wdata_o=32'h8000_0100. Then cmd=05 with if_pc_i=32'h8000_0100 -> read back 32'h8000_0100.
- Not halted; cmd=05 -> data_dut_dbg=32'hBAD0_0000, no strobes. Then cmd=01 with core_idle_i held 0 and HALT_TIMEOUT=16 -> dut_done 16 cycles after HALT_WAIT entry, halted_o=0, halt_o=1.
- cmd=02 after halt -> halt_o and halted_o 0, dut_done once. Assert rstn_i low during HALT_WAIT -> all outputs at reset values, no dut_done.
